// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage.
// Includes the control-bundle layout, the bubble encoding and the load-operation type.
package pipe_pkg;

  // Default width of the control bundle carried alongside each instruction.
  localparam int PIPE_CTRL_W = 32;

  // Control-bundle field offsets, shared by every stage that decodes the bundle.
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_W   = 8;
  localparam int CTRL_MEM_LSB    = 8;
  localparam int CTRL_MEM_W      = 4;
  localparam int CTRL_WB_LSB     = 12;
  localparam int CTRL_WB_W       = 5;
  localparam int CTRL_BR_LSB     = 17;
  localparam int CTRL_BR_W       = 3;

  // Bubble encoding: an empty slot has these valid and halt values, and a zero control bundle.
  localparam logic BUBBLE_VALID = 1'b0;
  localparam logic BUBBLE_HALT  = 1'b0;

  // Action taken by the stage register on a clock edge.
  typedef enum logic [1:0] {
    LD_HOLD   = 2'd0,
    LD_BUBBLE = 2'd1,
    LD_PASS   = 2'd2
  } ld_op_t;

  // A halt enters the stage only when it is real and no earlier halt has passed.
  function automatic logic halt_enters(input logic valid, input logic halt,
                                       input logic already_halted);
    return valid & halt & ~already_halted;
  endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Upstream/downstream bundle of the pipeline stage.
// The master modport is the upstream producer. The slave modport is the stage itself.
interface pipe_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_WORDS = 6,
  parameter int CTRL_WIDTH = PIPE_CTRL_W
);
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WORDS*DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0]            in_ctrl;
  logic                             in_halt;

  logic                             out_valid;
  logic [DATA_WORDS*DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0]            out_ctrl;
  logic                             out_halt;

  modport master (
    output in_valid, in_data, in_ctrl, in_halt,
    input  in_ready,
    input  out_valid, out_data, out_ctrl, out_halt
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, in_halt,
    output in_ready,
    output out_valid, out_data, out_ctrl, out_halt
  );
endinterface

// File: rtl/pipe_skid.sv
// One-entry skid buffer for pipe_stage.
// This module exists only when PIPE_STAGE_SKID_EN is defined.
// The skid captures an input that arrives during a stall. It then supplies that entry to the stage
// on the first edge after the stall ends. in_ready comes from a register, so it has no
// combinational path from stall.
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid #(
  parameter int PAYLOAD_WIDTH = 96,
  parameter int CTRL_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     in_valid,
  input  logic [PAYLOAD_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0]    in_ctrl,
  input  logic                     in_halt,
  output logic                     in_ready,
  output logic                     src_valid,
  output logic [PAYLOAD_WIDTH-1:0] src_data,
  output logic [CTRL_WIDTH-1:0]    src_ctrl,
  output logic                     src_halt
);

  logic                     full;
  logic [PAYLOAD_WIDTH-1:0] skid_data;
  logic [CTRL_WIDTH-1:0]    skid_ctrl;
  logic                     skid_halt;
  logic                     capture;

  assign capture  = stall & ~full & in_valid;
  assign in_ready = ~full;

  // The stage loads from the skid whenever it holds an entry. Otherwise it loads the live input.
  assign src_valid = full | in_valid;
  assign src_data  = full ? skid_data : in_data;
  assign src_ctrl  = full ? skid_ctrl : in_ctrl;
  assign src_halt  = full ? skid_halt : in_halt;

  // Occupancy: set by a capture during a stall. Cleared by any non-stalled edge, because that edge
  // either loads the entry or flushes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (stall) begin
      if (capture) full <= 1'b1;
    end else begin
      full <= 1'b0;
    end
  end

  // Entry storage. The occupancy flag guards it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
      skid_halt <= in_halt;
    end
  end

endmodule
`endif

// File: rtl/pipe_stage.sv
// Pipeline stage register with stall, flush, a sticky halt and a saturating bubble counter.
// Optional feature: define PIPE_STAGE_SKID_EN to add a one-entry skid buffer (pipe_skid).
// With the skid, in_ready comes from a register rather than being ~stall.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_WORDS = 6,
  parameter int CTRL_WIDTH = PIPE_CTRL_W,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stage_if.slave          bus,
  input  logic                 flush,
  input  logic                 stall,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] bubble_cnt
);

  localparam int PW = DATA_WORDS * DATA_WIDTH;

  // Increments the counter but stops at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic                  src_valid;
  logic [PW-1:0]         src_data;
  logic [CTRL_WIDTH-1:0] src_ctrl;
  logic                  src_halt;

  logic                  vld_p1;
  logic [PW-1:0]         data_p1;
  logic [CTRL_WIDTH-1:0] ctrl_p1;
  logic                  halt_p1;

  logic                  vld_nxt;
  logic [PW-1:0]         data_nxt;
  logic [CTRL_WIDTH-1:0] ctrl_nxt;
  logic                  halt_nxt;
  logic                  halted_nxt;
  logic                  bump;
  logic                  take_halt;
  ld_op_t                ld_op;

`ifdef PIPE_STAGE_SKID_EN
  pipe_skid #(
    .PAYLOAD_WIDTH (PW),
    .CTRL_WIDTH    (CTRL_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .in_valid  (bus.in_valid),
    .in_data   (bus.in_data),
    .in_ctrl   (bus.in_ctrl),
    .in_halt   (bus.in_halt),
    .in_ready  (bus.in_ready),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ctrl  (src_ctrl),
    .src_halt  (src_halt)
  );
`else
  assign bus.in_ready = ~stall;
  assign src_valid    = bus.in_valid;
  assign src_data     = bus.in_data;
  assign src_ctrl     = bus.in_ctrl;
  assign src_halt     = bus.in_halt;
`endif

  assign take_halt = halt_enters(src_valid, src_halt, halted);

  // Edge action, in priority order: stall holds the stage, then flush or halted loads a bubble,
  // otherwise the stage loads the source.
  always_comb begin
    ld_op = LD_PASS;
    if (stall) begin
      ld_op = LD_HOLD;
    end else if (flush || halted) begin
      ld_op = LD_BUBBLE;
    end
  end

  // Next register contents for the selected action.
  always_comb begin
    vld_nxt    = vld_p1;
    data_nxt   = data_p1;
    ctrl_nxt   = ctrl_p1;
    halt_nxt   = halt_p1;
    halted_nxt = halted;
    bump       = 1'b0;
    unique case (ld_op)
      LD_BUBBLE: begin
        vld_nxt  = BUBBLE_VALID;
        ctrl_nxt = '0;
        halt_nxt = BUBBLE_HALT;
        if (CLEAR_DATA != 0) data_nxt = '0;
        bump     = 1'b1;
      end
      LD_PASS: begin
        vld_nxt    = src_valid;
        data_nxt   = src_data;
        // The halt is carried only on out_halt; its control bundle is dropped.
        ctrl_nxt   = take_halt ? '0 : src_ctrl;
        halt_nxt   = take_halt;
        halted_nxt = take_halt;
        bump       = ~src_valid;
      end
      default: ;
    endcase
  end

  // ---- stage p1: registered outputs, sticky halt and bubble counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      ctrl_p1    <= '0;
      halt_p1    <= 1'b0;
      halted     <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      vld_p1     <= vld_nxt;
      data_p1    <= data_nxt;
      ctrl_p1    <= ctrl_nxt;
      halt_p1    <= halt_nxt;
      halted     <= halted_nxt;
      if (bump) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_ctrl  = ctrl_p1;
  assign bus.out_halt  = halt_p1;

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed scenarios followed by randomized traffic.
// All outputs are compared against a behavioural model of the stage.
module tb_pipe_stage;
  import pipe_pkg::*;

  localparam int DW      = 16;
  localparam int NW      = 6;
  localparam int CW      = 32;
  localparam int PW      = DW * NW;
  localparam int CNTW    = 4;
  localparam int CLEAR   = 1;
  localparam int CNT_MAX = (1 << CNTW) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct {
    logic          v;
    logic [PW-1:0] d;
    logic [CW-1:0] c;
    logic          h;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            stall;
  logic            halted;
  logic [CNTW-1:0] bubble_cnt;

  pipe_stage_if #(.DATA_WIDTH(DW), .DATA_WORDS(NW), .CTRL_WIDTH(CW)) bus ();

  pipe_stage #(
    .DATA_WIDTH (DW),
    .DATA_WORDS (NW),
    .CTRL_WIDTH (CW),
    .CLEAR_DATA (CLEAR),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .stall      (stall),
    .halted     (halted),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model state: what the stage should hold, plus skid contents as a queue.
  logic          m_v, m_h, m_halted;
  logic [PW-1:0] m_d;
  logic [CW-1:0] m_c;
  int            m_cnt;
  ent_t          skq[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t cur_in();
    ent_t e;
    e.v = bus.in_valid;
    e.d = bus.in_data;
    e.c = bus.in_ctrl;
    e.h = bus.in_halt;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [15:0] w, input logic [CW-1:0] c,
                       input logic h, input logic st, input logic fl, input logic r);
    bus.in_valid = v;
    bus.in_data  = {NW{w}};
    bus.in_ctrl  = c;
    bus.in_halt  = h;
    stall        = st;
    flush        = fl;
    rst          = r;
  endtask

  // Apply one clock with the current inputs, advance the model and compare every output.
  task automatic step();
    ent_t src;
    logic exp_ready;
    @(negedge clk);
    exp_ready = SKID ? (skq.size() == 0) : !stall;
    check("in_ready", 128'(bus.in_ready), 128'(exp_ready));
    if (rst) begin
      m_v = 0; m_d = '0; m_c = '0; m_h = 0; m_halted = 0; m_cnt = 0;
      skq.delete();
    end else if (stall) begin
      if (SKID && skq.size() == 0 && bus.in_valid) skq.push_back(cur_in());
    end else begin
      if (skq.size() != 0) src = skq.pop_front();
      else src = cur_in();
      if (flush || m_halted) begin
        m_v = 0; m_c = '0; m_h = 0;
        if (CLEAR != 0) m_d = '0;
      end else begin
        m_v = src.v;
        m_d = src.d;
        m_h = src.v && src.h;
        m_c = m_h ? '0 : src.c;
        if (m_h) m_halted = 1;
      end
      if (!m_v) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end
    @(posedge clk);
    #1;
    check("out_valid", 128'(bus.out_valid), 128'(m_v));
    check("out_data", 128'(bus.out_data), 128'(m_d));
    check("out_ctrl", 128'(bus.out_ctrl), 128'(m_c));
    check("out_halt", 128'(bus.out_halt), 128'(m_h));
    check("halted", 128'(halted), 128'(m_halted));
    check("bubble_cnt", 128'(bubble_cnt), 128'(m_cnt));
  endtask

  initial begin
    m_v = 0; m_d = '0; m_c = '0; m_h = 0; m_halted = 0; m_cnt = 0;
    drive(0, 16'h0, '0, 0, 0, 0, 1);
    step();
    check("rst_valid", 128'(bus.out_valid), 128'(0));
    check("rst_cnt", 128'(bubble_cnt), 128'(0));
    check("rst_halted", 128'(halted), 128'(0));

    // Plain load with one-cycle latency.
    drive(1, 16'h1234, 32'hA5, 0, 0, 0, 0);
    step();
    check("load_word0", 128'(bus.out_data[15:0]), 128'(16'h1234));
    check("load_ctrl", 128'(bus.out_ctrl), 128'(32'hA5));
    check("load_valid", 128'(bus.out_valid), 128'(1));

    // Stall with flush and new input holds; release with flush loads a bubble.
    drive(0, 16'h0, '0, 0, 0, 0, 1);
    step();
    drive(1, 16'h5555, 32'h11, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h9999, 32'h22, 0, 1, 1, 0);
      step();
      check("stall_hold", 128'(bus.out_data[15:0]), 128'(16'h5555));
    end
    drive(1, 16'h7777, 32'h33, 0, 0, 1, 0);
    step();
    check("flush_valid", 128'(bus.out_valid), 128'(0));
    check("flush_ctrl", 128'(bus.out_ctrl), 128'(0));
    check("flush_cnt", 128'(bubble_cnt), 128'(1));

    // Halt enters the stage, then later valid inputs become bubbles.
    drive(0, 16'h0, '0, 0, 0, 0, 1);
    step();
    drive(1, 16'hABCD, 32'hFF, 1, 0, 0, 0);
    step();
    check("halt_out", 128'(bus.out_halt), 128'(1));
    check("halt_ctrl", 128'(bus.out_ctrl), 128'(0));
    check("halt_sticky", 128'(halted), 128'(1));
    drive(1, 16'h1111, 32'h44, 0, 0, 0, 0);
    step();
    step();
    check("halt_bubble", 128'(bus.out_valid), 128'(0));
    check("halt_cnt", 128'(bubble_cnt), 128'(2));

    // Reset while stalled and halted clears everything; the next input loads normally.
    drive(1, 16'h2222, 32'h55, 0, 1, 0, 1);
    step();
    check("rst_mid_halted", 128'(halted), 128'(0));
    check("rst_mid_halt", 128'(bus.out_halt), 128'(0));
    drive(1, 16'hBEEF, 32'h66, 0, 0, 0, 0);
    step();
    check("post_rst_word0", 128'(bus.out_data[15:0]), 128'(16'hBEEF));
    check("post_rst_valid", 128'(bus.out_valid), 128'(1));

    // Counter saturation with a narrow counter.
    drive(0, 16'h0, '0, 0, 0, 0, 1);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(0, 16'h0, '0, 0, 0, 0, 0);
      step();
    end
    check("cnt_saturate", 128'(bubble_cnt), 128'(4'hF));

`ifdef PIPE_STAGE_SKID_EN
    // Skid captures during a stall and replays on release.
    drive(0, 16'h0, '0, 0, 0, 0, 1);
    step();
    drive(1, 16'h0042, 32'h42, 0, 1, 0, 0);
    step();
    check("skid_ready", 128'(bus.in_ready), 128'(0));
    drive(1, 16'h0099, 32'h99, 0, 0, 0, 0);
    step();
    check("skid_word0", 128'(bus.out_data[15:0]), 128'(16'h0042));
    drive(1, 16'h0077, 32'h77, 0, 0, 0, 0);
    step();
    check("skid_next", 128'(bus.out_data[15:0]), 128'(16'h0077));
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(63) == 0);
      stall        = ($urandom_range(3) == 0);
      flush        = ($urandom_range(7) == 0);
      bus.in_valid = ($urandom_range(3) != 0);
      bus.in_halt  = ($urandom_range(31) == 0);
      bus.in_data  = {$urandom(), $urandom(), $urandom()};
      bus.in_ctrl  = $urandom();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
